// File: rtl/motor_fault_pkg.sv
// Shared fault codes and class indices for the sequential motor fault classifier.
// Fault codes are ordered by priority, so a numeric max is also a priority max.
package motor_fault_pkg;
  localparam logic [2:0] FAULT_NONE   = 3'b000;
  localparam logic [2:0] FAULT_ROTOR  = 3'b001;
  localparam logic [2:0] FAULT_STATOR = 3'b010;
  localparam logic [2:0] FAULT_VIB    = 3'b011;
  localparam logic [2:0] FAULT_UV     = 3'b100;

  localparam int IDX_ROTOR   = 0;
  localparam int IDX_STATOR  = 1;
  localparam int IDX_VIB     = 2;
  localparam int IDX_UV      = 3;
  localparam int NUM_CLASSES = 4;
endpackage

// File: rtl/persist_filter.sv
// Debounce for one fault class: PERSIST consecutive qualifying samples toggle the active flag.
// The counter watches the assert condition while inactive and the release condition while active.
module persist_filter #(
  parameter int PERSIST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic assert_c,
  input  logic release_c,
  output logic active
);
  localparam int CW = $clog2(PERSIST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERSIST - 1);

  logic [CW-1:0] cnt;
  logic          qual;

  assign qual = active ? release_c : assert_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (en) begin
      if (!qual) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        active <= ~active;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/fault_classifier_seq.sv
// Sequential motor fault classifier: hysteresis thresholds, per-class debounce,
// priority encode, a one-cycle valid pulse and a software-cleared sticky latch.
module fault_classifier_seq
  import motor_fault_pkg::*;
#(
  parameter int W        = 16,
  parameter int PERSIST  = 4,
  parameter int HYST     = 4,
  parameter int V_MIN    = 180,
  parameter int VIB_MAX  = 80,
  parameter int TEMP_MAX = 80,
  parameter int CUR_MAX  = 80,
  parameter int FLUX_MIN = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_valid,
  input  logic [W-1:0] avg_current,
  input  logic [W-1:0] avg_vibration,
  input  logic [W-1:0] avg_temperature,
  input  logic [W-1:0] rotor_flux,
  input  logic [W-1:0] stator_flux,
  input  logic [W-1:0] voltage,
  input  logic         clear_latch,
  output logic [2:0]   fault_type,
  output logic         fault_valid,
  output logic         fault_latched,
  output logic [2:0]   latched_type
);
  // Upper release levels carry an extra bit so threshold+HYST cannot wrap;
  // lower release levels clamp at zero.
  localparam logic [W:0]   UV_REL   = (W+1)'(V_MIN) + (W+1)'(HYST);
  localparam logic [W:0]   FLUX_REL = (W+1)'(FLUX_MIN) + (W+1)'(HYST);
  localparam logic [W-1:0] VIB_REL  = (VIB_MAX  > HYST) ? W'(VIB_MAX  - HYST) : '0;
  localparam logic [W-1:0] TEMP_REL = (TEMP_MAX > HYST) ? W'(TEMP_MAX - HYST) : '0;
  localparam logic [W-1:0] CUR_REL  = (CUR_MAX  > HYST) ? W'(CUR_MAX  - HYST) : '0;

  logic [NUM_CLASSES-1:0] assert_c;
  logic [NUM_CLASSES-1:0] release_c;
  logic [NUM_CLASSES-1:0] active;

  always_comb begin
    assert_c  = '0;
    release_c = '0;
    assert_c[IDX_UV]      = voltage < W'(V_MIN);
    release_c[IDX_UV]     = {1'b0, voltage} >= UV_REL;
    assert_c[IDX_VIB]     = avg_vibration > W'(VIB_MAX);
    release_c[IDX_VIB]    = avg_vibration <= VIB_REL;
    assert_c[IDX_STATOR]  = (stator_flux < W'(FLUX_MIN)) && (avg_temperature > W'(TEMP_MAX));
    release_c[IDX_STATOR] = ({1'b0, stator_flux} >= FLUX_REL) || (avg_temperature <= TEMP_REL);
    assert_c[IDX_ROTOR]   = (rotor_flux < W'(FLUX_MIN)) && (avg_current > W'(CUR_MAX));
    release_c[IDX_ROTOR]  = ({1'b0, rotor_flux} >= FLUX_REL) || (avg_current <= CUR_REL);
  end

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_filt
    persist_filter #(.PERSIST(PERSIST)) u_filt (
      .clk       (clk),
      .rst       (rst),
      .en        (sample_valid),
      .assert_c  (assert_c[g]),
      .release_c (release_c[g]),
      .active    (active[g])
    );
  end

  // Active flags are registered and only move on sample edges, so the
  // encoded code is stable for the whole cycle in which fault_valid pulses.
  always_comb begin
    fault_type = FAULT_NONE;
    if (active[IDX_UV])          fault_type = FAULT_UV;
    else if (active[IDX_VIB])    fault_type = FAULT_VIB;
    else if (active[IDX_STATOR]) fault_type = FAULT_STATOR;
    else if (active[IDX_ROTOR])  fault_type = FAULT_ROTOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_valid   <= 1'b0;
      fault_latched <= 1'b0;
      latched_type  <= FAULT_NONE;
    end else begin
      fault_valid <= sample_valid;
      if (fault_valid && (fault_type != FAULT_NONE)) begin
        fault_latched <= 1'b1;
        if (clear_latch || (fault_type > latched_type))
          latched_type <= fault_type;
      end else if (clear_latch) begin
        fault_latched <= 1'b0;
        latched_type  <= FAULT_NONE;
      end
    end
  end
endmodule

// File: tb/tb_fault_classifier_seq.sv
// Directed bench for fault_classifier_seq with PERSIST=3, HYST=4.
module tb_fault_classifier_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         sample_valid;
  logic [W-1:0] avg_current, avg_vibration, avg_temperature;
  logic [W-1:0] rotor_flux, stator_flux, voltage;
  logic         clear_latch;
  logic [2:0]   fault_type;
  logic         fault_valid;
  logic         fault_latched;
  logic [2:0]   latched_type;

  int n_tests = 0;
  int n_fail  = 0;

  fault_classifier_seq #(.W(W), .PERSIST(3), .HYST(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_valid    (sample_valid),
    .avg_current     (avg_current),
    .avg_vibration   (avg_vibration),
    .avg_temperature (avg_temperature),
    .rotor_flux      (rotor_flux),
    .stator_flux     (stator_flux),
    .voltage         (voltage),
    .clear_latch     (clear_latch),
    .fault_type      (fault_type),
    .fault_valid     (fault_valid),
    .fault_latched   (fault_latched),
    .latched_type    (latched_type)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample cycle; returns #1 after the capturing edge.
  task automatic do_sample();
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b1; clear_latch = 1'b0;
    avg_current = 40; avg_vibration = 20; avg_temperature = 40;
    rotor_flux = 100; stator_flux = 100; voltage = 100;
    idle(); idle();
    chk("rst_type", 8'(fault_type), 8'h0);
    chk("rst_valid", 8'(fault_valid), 8'h0);
    chk("rst_latched", 8'(fault_latched), 8'h0);
    chk("rst_ltype", 8'(latched_type), 8'h0);
    rst = 1'b0; sample_valid = 1'b0;

    // Persistence: undervoltage needs three samples counted from zero after reset
    voltage = 170;
    do_sample(); chk("uv_s1_type", 8'(fault_type), 8'h0); chk("uv_s1_valid", 8'(fault_valid), 8'h1);
    do_sample(); chk("uv_s2_type", 8'(fault_type), 8'h0); chk("uv_s2_valid", 8'(fault_valid), 8'h1);
    idle();      chk("uv_idle_valid", 8'(fault_valid), 8'h0);
    do_sample(); chk("uv_s3_type", 8'(fault_type), 8'h4);
    idle();
    chk("uv_latched", 8'(fault_latched), 8'h1);
    chk("uv_ltype", 8'(latched_type), 8'h4);

    // Hysteresis: 182 sits inside the band, 184 releases after three samples
    voltage = 182;
    for (int i = 0; i < 5; i++) begin
      do_sample(); chk("hyst_hold", 8'(fault_type), 8'h4);
    end
    voltage = 184;
    do_sample(); chk("hyst_rel1", 8'(fault_type), 8'h4);
    do_sample(); chk("hyst_rel2", 8'(fault_type), 8'h4);
    do_sample(); chk("hyst_rel3", 8'(fault_type), 8'h0);
    idle();
    chk("hyst_ltype", 8'(latched_type), 8'h4);
    chk("hyst_latched", 8'(fault_latched), 8'h1);

    // Interrupted debounce on vibration, with idle gaps inside the run
    voltage = 230;
    avg_vibration = 90; do_sample(); chk("vib_a1", 8'(fault_type), 8'h0);
    avg_vibration = 90; do_sample(); chk("vib_a2", 8'(fault_type), 8'h0);
    avg_vibration = 50; do_sample(); chk("vib_break", 8'(fault_type), 8'h0);
    avg_vibration = 90; do_sample(); chk("vib_b1", 8'(fault_type), 8'h0);
    idle(); idle();
    do_sample(); chk("vib_b2", 8'(fault_type), 8'h0);
    idle();
    do_sample(); chk("vib_b3", 8'(fault_type), 8'h3);
    idle();
    chk("vib_no_downgrade", 8'(latched_type), 8'h4);
    avg_vibration = 20;
    do_sample(); do_sample(); do_sample();
    chk("vib_release", 8'(fault_type), 8'h0);
    idle();
    clear_latch = 1'b1; idle(); clear_latch = 1'b0;
    chk("clr1_latched", 8'(fault_latched), 8'h0);
    chk("clr1_ltype", 8'(latched_type), 8'h0);

    // Priority and latch upgrade
    rotor_flux = 50; avg_current = 90;
    do_sample(); do_sample(); chk("rot_s2", 8'(fault_type), 8'h0);
    do_sample(); chk("rot_s3", 8'(fault_type), 8'h1);
    idle();
    chk("rot_ltype", 8'(latched_type), 8'h1);
    chk("rot_latched", 8'(fault_latched), 8'h1);
    avg_vibration = 90;
    do_sample(); do_sample(); chk("pri_s2", 8'(fault_type), 8'h1);
    do_sample(); chk("pri_vib", 8'(fault_type), 8'h3);
    idle();
    chk("pri_upgrade", 8'(latched_type), 8'h3);
    avg_vibration = 20;
    do_sample(); do_sample(); do_sample();
    chk("pri_back_rotor", 8'(fault_type), 8'h1);
    idle();
    chk("pri_keep_ltype", 8'(latched_type), 8'h3);

    // Clear colliding with a fault_valid cycle carrying ROTOR: new fault wins
    do_sample();
    chk("coll_valid", 8'(fault_valid), 8'h1);
    clear_latch = 1'b1; idle(); clear_latch = 1'b0;
    chk("coll_ltype", 8'(latched_type), 8'h1);
    chk("coll_latched", 8'(fault_latched), 8'h1);
    clear_latch = 1'b1; idle(); clear_latch = 1'b0;
    chk("clr2_latched", 8'(fault_latched), 8'h0);
    chk("clr2_ltype", 8'(latched_type), 8'h0);
    chk("clr2_type", 8'(fault_type), 8'h1);

    // Reset mid-debounce discards progress
    rotor_flux = 100; avg_current = 40; voltage = 170;
    do_sample(); do_sample();
    rst = 1'b1; idle(); rst = 1'b0;
    chk("rst2_type", 8'(fault_type), 8'h0);
    do_sample(); do_sample(); chk("rst2_s2", 8'(fault_type), 8'h0);
    do_sample(); chk("rst2_s3", 8'(fault_type), 8'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fault_classifier_seq.md
Name: fault_classifier_seq

Overview:
- Sequential, parametrised successor to the combinational motor fault classifier.
- Per-class fault conditions use assert/release thresholds with hysteresis, then a per-class persistence (debounce) filter, then a fixed-priority encode.
- Adds a registered output with a valid pulse and a sticky latched-fault register cleared by software.
- Sits after the sensor averaging stage; feeds the fault logger and the protection controller.

Parameters:
- W, 16, width of all sensor inputs
- PERSIST, 4, consecutive qualifying samples needed to enter or leave a fault class (>=1)
- HYST, 4, hysteresis band applied to every threshold on release
- V_MIN, 180, undervoltage threshold
- VIB_MAX, 80, vibration threshold
- TEMP_MAX, 80, temperature threshold
- CUR_MAX, 80, current threshold
- FLUX_MIN, 60, rotor/stator flux threshold

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_valid  in  1  all sensor inputs valid this cycle
- avg_current  in  W  averaged phase current
- avg_vibration  in  W  averaged vibration
- avg_temperature  in  W  averaged winding temperature
- rotor_flux  in  W  rotor flux estimate
- stator_flux  in  W  stator flux estimate
- voltage  in  W  supply voltage
- clear_latch  in  1  single-cycle request to clear the latched fault
- fault_type  out  3  current debounced fault code
- fault_valid  out  1  one-cycle pulse; fault_type updated
- fault_latched  out  1  sticky: a nonzero fault has occurred
- latched_type  out  3  highest-priority fault seen since the last clear

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: fault_type=000, fault_valid=0, fault_latched=0, latched_type=000. All persistence counters are 0 and all class-active flags are 0. Reset asserted mid-debounce discards all progress.
- Fault codes and priority (highest first):
  - UV=100: assert when voltage<V_MIN; release when voltage>=V_MIN+HYST.
  - VIB=011: assert when vib>VIB_MAX; release when vib<=VIB_MAX-HYST.
  - STATOR=010: assert when stator_flux<FLUX_MIN AND temp>TEMP_MAX; release when stator_flux>=FLUX_MIN+HYST OR temp<=TEMP_MAX-HYST.
  - ROTOR=001: same form as STATOR, using rotor_flux and CUR_MAX.
  - None active: 000.
- Width rules: threshold+HYST is computed in W+1 bits (no wrap). threshold-HYST saturates at 0. All comparisons are unsigned.
- Per-class filter, evaluated only on cycles with sample_valid=1; all state holds otherwise:
  - Inactive: assert condition true -> cnt++. If cnt reaches PERSIST, set active and cnt=0. Assert condition false -> cnt=0 (a non-qualifying sample restarts the count).
  - Active: release condition true -> cnt++. If cnt reaches PERSIST, clear active and cnt=0. Release condition false -> cnt=0.
  - Samples between the assert and release thresholds keep an active class active and reset its release count.
  - PERSIST=1 gives a single-sample response.
  - Counter width is $clog2(PERSIST+1).
- Output timing:
  - The cycle after any sample_valid: fault_type = priority encode of the active flags, and fault_valid=1 for exactly one cycle. The pulse fires even if fault_type is unchanged.
  - Latency from the qualifying sample to fault_type is 1 cycle.
- Latch:
  - On a fault_valid cycle with nonzero fault_type: fault_latched=1, latched_type=max(latched_type, fault_type). A higher-priority fault upgrades the latch; a lower one never downgrades it.
  - clear_latch sets fault_latched=0 and latched_type=000, effective next cycle.
  - clear_latch in the same cycle as a nonzero fault_type update: the new fault wins, and latched_type=the new fault_type (prior contents are dropped).
  - clear_latch with no update: clear only.
  - The latch is not affected by faults deactivating.

Decomposition:
- Package motor_fault_pkg holds:
  - localparams FAULT_NONE/ROTOR/STATOR/VIB/UV (3-bit)
  - class index constants (ROTOR=0..UV=3) and NUM_CLASSES=4
- Sub-module persist_filter (params PERSIST; ports clk, rst, en, assert_c, release_c, active), instantiated 4x.
- Threshold/hysteresis comparators and the priority encoder stay in the top module.

Test Plan (PERSIST=3, HYST=4, defaults otherwise; nominal: V=230, vib=20, fluxes=100, temp=40, cur=40):
- Reset: assert rst 2 cycles with voltage=100 applied -> all outputs 0, and the first sample after reset starts the count from 0.
- Persistence: voltage=170 on samples 1,2 -> fault_type=000 with fault_valid pulses. Sample 3 -> fault_type=100 one cycle later; fault_latched=1; latched_type=100.
- Hysteresis: from UV active, voltage=182 for 5 samples -> stays 100. Then voltage=184 for 3 samples -> 000 after the 3rd; latched_type stays 100.
- Interrupted debounce: vib=90,90,50,90,90 -> 000 throughout. A further 90 (third consecutive) -> 011. Idle cycles without sample_valid inserted between samples do not break the count.
- Priority/upgrade: rotor_flux=50, cur=90 for 3 samples -> 001, latched 001. Then vib=90 for 3 samples -> 011, latched_type upgrades to 011. Then clear vib only -> fault_type returns to 001, latched_type stays 011.
- Clear collision: clear_latch coincident with a fault_valid cycle carrying 001 -> latched_type=001, fault_latched=1. A clear_latch with no update -> both 0.
